// File: rtl/otbn_keccak_plane_seq.sv
`default_nettype none
// ============================================================================
// Module      : otbn_keccak_plane_seq
// Description : Sequencer that streams Keccak planes through an external
//               combinational plane unit. A theta job folds five input
//               planes into a column-parity accumulator and emits one D-plane.
//               A chi job passes five planes through the unit one at a time,
//               alternating input and output beats.
//               Only a lane width of 64 bits is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_keccak_plane_seq #(
    parameter int LaneW = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 op_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [5*LaneW-1:0]   in_plane_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [5*LaneW-1:0]   out_plane_o,
    output logic                 pu_en_o,
    output logic                 pu_op_o,
    output logic [4*LaneW-1:0]   pu_operand_a_o,
    output logic [4*LaneW-1:0]   pu_operand_b_o,
    input  logic [4*LaneW-1:0]   pu_rs0_i,
    input  logic [4*LaneW-1:0]   pu_rs1_i
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RECV = 3'd1;
    localparam logic [2:0] c_CALC = 3'd2;
    localparam logic [2:0] c_SEND = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [2:0] c_LAST_BEAT = 3'd4;
    localparam logic       c_OP_THETA  = 1'b0;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_op;
    logic [2:0]         r_cnt;
    logic [5*LaneW-1:0] r_c;
    logic [5*LaneW-1:0] r_w;
    logic [5*LaneW-1:0] r_r;

    logic               w_in_hs;
    logic               w_out_hs;
    logic [5*LaneW-1:0] w_src;
    logic [5*LaneW-1:0] w_result;
    logic               w_unused_rs1;

    // Theta works on the parity accumulator, chi on the latched plane.
    assign w_src    = (r_op == c_OP_THETA) ? r_c : r_w;
    // Lanes 0..3 come back on rs0, lane 4 on the low lane of rs1.
    assign w_result = {pu_rs1_i[LaneW-1:0], pu_rs0_i};
    assign w_unused_rs1 = ^pu_rs1_i[4*LaneW-1:LaneW];

    assign w_in_hs  = in_valid_i & in_ready_o;
    assign w_out_hs = out_valid_o & out_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and outputs; every output is forced low while reset is held.
    always_comb begin
        w_state_next   = r_state;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        in_ready_o     = 1'b0;
        out_valid_o    = 1'b0;
        out_plane_o    = '0;
        pu_en_o        = 1'b0;
        pu_op_o        = 1'b0;
        pu_operand_a_o = '0;
        pu_operand_b_o = '0;
        if (rst_ni) begin
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        w_state_next = c_RECV;
                    end
                end
                c_RECV: begin
                    busy_o     = 1'b1;
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        if (r_op != c_OP_THETA || r_cnt == c_LAST_BEAT) begin
                            w_state_next = c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    busy_o         = 1'b1;
                    pu_en_o        = 1'b1;
                    pu_op_o        = r_op;
                    pu_operand_a_o = w_src[4*LaneW-1:0];
                    pu_operand_b_o = {{(3*LaneW){1'b0}}, w_src[5*LaneW-1:4*LaneW]};
                    w_state_next   = c_SEND;
                end
                c_SEND: begin
                    busy_o      = 1'b1;
                    out_valid_o = 1'b1;
                    out_plane_o = r_r;
                    if (out_ready_i) begin
                        if (r_op == c_OP_THETA || r_cnt == c_LAST_BEAT) begin
                            w_state_next = c_DONE;
                        end else begin
                            w_state_next = c_RECV;
                        end
                    end
                end
                c_DONE: begin
                    busy_o       = 1'b1;
                    done_o       = 1'b1;
                    w_state_next = c_IDLE;
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    // Job datapath: op latch, parity accumulator, work/result planes, beat count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op  <= 1'b0;
            r_cnt <= 3'd0;
            r_c   <= '0;
            r_w   <= '0;
            r_r   <= '0;
        end else begin
            if (r_state == c_IDLE && start_i) begin
                r_op  <= op_i;
                r_cnt <= 3'd0;
                r_c   <= '0;
            end
            if (w_in_hs) begin
                if (r_op == c_OP_THETA) begin
                    r_c   <= r_c ^ in_plane_i;
                    r_cnt <= (r_cnt == c_LAST_BEAT) ? 3'd0 : r_cnt + 3'd1;
                end else begin
                    r_w <= in_plane_i;
                end
            end
            if (r_state == c_CALC) begin
                r_r <= w_result;
            end
            if (w_out_hs && r_op != c_OP_THETA) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otbn_keccak_plane_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_otbn_keccak_plane_seq
// Description : Self-checking bench for the Keccak plane sequencer, with a
//               behavioural theta/chi plane unit attached to its operand ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otbn_keccak_plane_seq;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MSB  = 64'h8000_0000_0000_0000;

    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic         op_i;
    logic         busy_o;
    logic         done_o;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [319:0] in_plane_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [319:0] out_plane_o;
    logic         pu_en_o;
    logic         pu_op_o;
    logic [255:0] pu_operand_a_o;
    logic [255:0] pu_operand_b_o;
    logic [255:0] pu_rs0_i;
    logic [255:0] pu_rs1_i;

    int checks;
    int failures;

    typedef struct packed {
        logic             op;
        logic [4:0][319:0] pin;
        logic [4:0][319:0] pexp;
    } vec_t;

    vec_t vecs [5];

    otbn_keccak_plane_seq #(.LaneW(64)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .op_i           (op_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_plane_i     (in_plane_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_plane_o    (out_plane_o),
        .pu_en_o        (pu_en_o),
        .pu_op_o        (pu_op_o),
        .pu_operand_a_o (pu_operand_a_o),
        .pu_operand_b_o (pu_operand_b_o),
        .pu_rs0_i       (pu_rs0_i),
        .pu_rs1_i       (pu_rs1_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural plane unit: theta D-plane or chi, upper rs1 lanes carry junk.
    logic [63:0] pa [5];
    logic [63:0] pr [5];
    always_comb begin
        for (int x = 0; x < 4; x++) pa[x] = pu_operand_a_o[64*x +: 64];
        pa[4] = pu_operand_b_o[63:0];
        for (int x = 0; x < 5; x++) begin
            if (pu_op_o) pr[x] = pa[x] ^ (~pa[(x+1)%5] & pa[(x+2)%5]);
            else         pr[x] = pa[(x+4)%5] ^ {pa[(x+1)%5][62:0], pa[(x+1)%5][63]};
        end
        pu_rs0_i = {pr[3], pr[2], pr[1], pr[0]};
        pu_rs1_i = {{3{64'hDEAD_BEEF_0BAD_F00D}}, pr[4]};
    end

    function automatic logic [319:0] pl(input logic [63:0] l0, input logic [63:0] l1,
                                        input logic [63:0] l2, input logic [63:0] l3,
                                        input logic [63:0] l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk_i);
    endtask

    // One complete job from the table; optional SEND stalls and stray start pulses.
    task automatic run_job(input int vi, input int stall, input bit poke);
        vec_t v;
        int   oi;
        v = vecs[vi];
        start_i = 1'b1;
        op_i    = v.op;
        step;
        start_i = 1'b0;
        op_i    = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("in_ready_recv", in_ready_o, 1);
        for (int b = 0; b < 5; b++) begin
            in_valid_i = 1'b1;
            in_plane_i = v.pin[b];
            if (poke) begin start_i = 1'b1; op_i = ~v.op; end
            step;
            in_valid_i = 1'b0;
            in_plane_i = '0;
            start_i    = 1'b0;
            op_i       = 1'b0;
            if (v.op || b == 4) begin
                chk("calc_pu_en", pu_en_o, 1);
                chk("calc_in_ready", in_ready_o, 0);
                chk("calc_pu_op", pu_op_o, v.op);
                chk("calc_opb_hi", pu_operand_b_o[255:64], 0);
                step;
                oi = v.op ? b : 0;
                chk("send_valid", out_valid_o, 1);
                chk("send_plane", out_plane_o, v.pexp[oi]);
                chk("send_pu_en", pu_en_o, 0);
                chk("send_opa_zero", pu_operand_a_o, 0);
                for (int s = 0; s < stall; s++) begin
                    if (poke) begin start_i = 1'b1; op_i = ~v.op; end
                    step;
                    start_i = 1'b0;
                    op_i    = 1'b0;
                    chk("stall_plane", out_plane_o, v.pexp[oi]);
                    chk("stall_valid", out_valid_o, 1);
                    chk("stall_in_ready", in_ready_o, 0);
                    chk("stall_pu_en", pu_en_o, 0);
                end
                out_ready_i = 1'b1;
                if (poke) begin start_i = 1'b1; op_i = ~v.op; end
                step;
                out_ready_i = 1'b0;
                start_i     = 1'b0;
                op_i        = 1'b0;
                chk("post_send_plane_zero", out_plane_o, 0);
                if (b == 4) begin
                    chk("done_pulse", done_o, 1);
                    chk("done_valid_low", out_valid_o, 0);
                    step;
                    chk("idle_busy", busy_o, 0);
                    chk("idle_done", done_o, 0);
                end else begin
                    chk("chi_back_recv", in_ready_o, 1);
                    chk("chi_no_done", done_o, 0);
                end
            end else begin
                chk("theta_recv_ready", in_ready_o, 1);
                chk("theta_recv_novalid", out_valid_o, 0);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_ni      = 1'b0;
        start_i     = 1'b1;
        op_i        = 1'b1;
        in_valid_i  = 1'b1;
        in_plane_i  = '1;
        out_ready_i = 1'b1;

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        // Theta, single set bit in plane 0 lane 0.
        vecs[0].op      = 1'b0;
        vecs[0].pin[0]  = pl(64'd1, 0, 0, 0, 0);
        vecs[0].pexp[0] = pl(0, 64'd1, 0, 0, 64'd2);
        // Theta, all-zero planes.
        vecs[1].op      = 1'b0;
        // Theta, lane-3 MSB parity (odd count) plus lane-1 bit, rotation wrap.
        vecs[2].op      = 1'b0;
        vecs[2].pin[0]  = pl(0, 0, 0, c_MSB, 0);
        vecs[2].pin[1]  = pl(0, 64'd1, 0, 0, 0);
        vecs[2].pin[2]  = pl(0, 0, 0, c_MSB, 0);
        vecs[2].pin[4]  = pl(0, 0, 0, c_MSB, 0);
        vecs[2].pexp[0] = pl(64'd2, 0, 0, 0, c_MSB);
        // Chi, lane 2 all-ones in every plane.
        vecs[3].op = 1'b1;
        for (int b = 0; b < 5; b++) begin
            vecs[3].pin[b]  = pl(0, 0, c_ONES, 0, 0);
            vecs[3].pexp[b] = pl(c_ONES, 0, c_ONES, 0, 0);
        end
        // Chi, five distinct planes.
        vecs[4].op      = 1'b1;
        vecs[4].pin[0]  = pl(64'd1, 64'd2, 64'd4, 64'd8, 64'd16);
        vecs[4].pexp[0] = pl(64'd5, 64'd10, 64'd20, 64'd9, 64'd18);
        vecs[4].pin[1]  = pl(c_ONES, c_ONES, c_ONES, c_ONES, c_ONES);
        vecs[4].pexp[1] = pl(c_ONES, c_ONES, c_ONES, c_ONES, c_ONES);
        vecs[4].pin[2]  = pl(64'hF0, 64'hFF, 64'h0F, 0, 0);
        vecs[4].pexp[2] = pl(64'hF0, 64'hFF, 64'h0F, 64'hF0, 64'h0F);
        vecs[4].pin[3]  = '0;
        vecs[4].pexp[3] = '0;
        vecs[4].pin[4]  = pl(0, 0, 0, 0, c_ONES);
        vecs[4].pexp[4] = pl(0, 0, c_ONES, 0, c_ONES);

        // Reset with every input asserted: all outputs low.
        step;
        step;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_plane", out_plane_o, 0);
        chk("rst_pu_en", pu_en_o, 0);
        chk("rst_pu_op", pu_op_o, 0);
        chk("rst_opa", pu_operand_a_o, 0);
        chk("rst_opb", pu_operand_b_o, 0);
        start_i     = 1'b0;
        op_i        = 1'b0;
        in_valid_i  = 1'b0;
        in_plane_i  = '0;
        out_ready_i = 1'b0;
        rst_ni      = 1'b1;
        step;
        chk("idle_no_start", busy_o, 0);

        for (int i = 0; i < 5; i++) run_job(i, 0, 1'b0);

        // Chi with a three-cycle output stall on every beat.
        run_job(3, 3, 1'b0);
        // Stray start pulses with toggled op while busy.
        run_job(0, 2, 1'b1);
        run_job(4, 0, 1'b1);

        // Abort a theta job after two beats, then a clean all-zero job.
        start_i = 1'b1;
        op_i    = 1'b0;
        step;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_plane_i = pl(64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
        step;
        in_plane_i = pl(64'd7, 64'd9, 64'd11, 64'd13, 64'd15);
        step;
        in_valid_i = 1'b0;
        in_plane_i = '0;
        rst_ni     = 1'b0;
        #1;
        chk("midjob_rst_busy", busy_o, 0);
        chk("midjob_rst_in_ready", in_ready_o, 0);
        step;
        chk("midjob_rst_done", done_o, 0);
        rst_ni = 1'b1;
        step;
        chk("after_rst_busy", busy_o, 0);
        chk("after_rst_done", done_o, 0);
        run_job(1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otbn_keccak_plane_seq.md
OTBN_KECCAK_PLANE_SEQ -- requirements
Module: otbn_keccak_plane_seq

Interface
REQ-001 SHALL have parameter LaneW, default 64, meaning Keccak lane width in bits; only 64 is supported.
REQ-002 SHALL have port clk_i  input  1  clock.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_i  input  1  begin a job; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  1  job type: 0 = theta (column parity to D-plane), 1 = chi; sampled with start_i.
REQ-006 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-007 SHALL have port done_o  output  1  one-cycle pulse at job end.
REQ-008 SHALL have port in_valid_i  input  1, in_ready_o  output  1, in_plane_i  input  320  as the input plane stream, with lane x at bits [64x+63:64x].
REQ-009 SHALL have port out_valid_o  output  1, out_ready_i  input  1, out_plane_o  output  320  as the output plane stream, with the same lane packing.
REQ-010 SHALL have port pu_en_o  output  1  plane-unit operand enable, which drives the plane unit's blankers.
REQ-011 SHALL have port pu_op_o  output  1  plane-unit op: 0 = theta, 1 = chi.
REQ-012 SHALL have ports pu_operand_a_o  output  256 and pu_operand_b_o  output  256  as plane-unit operands.
REQ-013 SHALL have ports pu_rs0_i  input  256 and pu_rs1_i  input  256  as combinational plane-unit results.

Function
REQ-014 SHALL implement FSM states IDLE, RECV, CALC, SEND, DONE.
REQ-015 IDLE: on start_i=1, SHALL latch op_i, clear the parity accumulator C (320 b) and the beat counter cnt (3 b), and go to RECV; start_i SHALL be ignored in all other states.
REQ-016 RECV: SHALL drive in_ready_o=1; no other state SHALL assert in_ready_o.
REQ-017 RECV, theta, on an input handshake: SHALL update C <= C ^ in_plane_i and cnt++; when cnt was 4, SHALL clear cnt and go to CALC, otherwise stay in RECV.
REQ-018 RECV, chi, on an input handshake: SHALL latch in_plane_i into the work register W and go to CALC.
REQ-019 CALC (exactly 1 cycle): SHALL assert pu_en_o=1, drive pu_op_o=latched op, use source S=C (theta) or S=W (chi), and register the result into R, then go to SEND.
REQ-020 Operand packing SHALL be pu_operand_a_o = S lanes 0..3 and pu_operand_b_o[63:0] = S lane 4, with pu_operand_b_o[255:64] = 0.
REQ-021 Result unpacking SHALL be R lane x = pu_rs0_i[64x+63:64x] for x = 0..3 and R lane 4 = pu_rs1_i[63:0]; pu_rs1_i[255:64] SHALL be ignored.
REQ-022 Outside CALC, pu_en_o SHALL be 0 and both pu_operand outputs SHALL be 0.
REQ-023 SEND: SHALL drive out_valid_o=1 and out_plane_o=R, holding both stable until out_ready_i=1.
REQ-024 SEND, on an output handshake: theta SHALL go to DONE; chi SHALL do cnt++ and go to DONE if cnt was 4, otherwise go to RECV.
REQ-025 DONE: SHALL pulse done_o=1 for one cycle, then go to IDLE.
REQ-026 Chi latency: with no stalls, a plane accepted in cycle t SHALL give CALC in t+1 and out_valid_o=1 in t+2.
REQ-027 Theta latency: after the 5th input handshake in cycle t, out_valid_o SHALL be 1 in t+2.
REQ-028 A theta job SHALL consume exactly 5 input beats and produce 1 output beat; a chi job SHALL consume 5 and produce 5 in alternating order; out_plane_o SHALL be 0 when out_valid_o=0.

Reset
REQ-029 While rst_ni=0 at a clk_i edge: state SHALL be IDLE, and C, W, R, cnt and the latched op SHALL be 0.
REQ-030 While rst_ni=0 at a clk_i edge: every output SHALL be 0, including busy_o, done_o, in_ready_o, out_valid_o and pu_en_o.
REQ-031 Reset mid-job SHALL abort it with no done_o pulse; the next job SHALL start from cleared state.

Verification
REQ-032 Theta, planes 0..4 with plane0 lane0=1 and all else 0 -> one output beat with lanes [0,1,0,0,2], then done_o one cycle after the handshake.
REQ-033 Chi, each of 5 planes with lanes [0,0,all-ones,0,0] -> 5 output beats, each with lanes [all-ones,0,all-ones,0,0].
REQ-034 Chi, out_ready_i held 0 for 3 cycles in SEND -> out_plane_o stable, in_ready_o=0, pu_en_o=0 throughout.
REQ-035 start_i pulsed while busy with op_i toggled -> no effect on the running job or its result.
REQ-036 rst_ni=0 for 1 cycle after the 2nd theta beat, then a fresh theta job with all-zero planes -> output lanes all 0 (no stale parity).
